// File: rtl/line_mem_pkg.sv
// Shared types for the line memory responder: request/response type codes,
// FSM states and the line width.
package line_mem_pkg;

  localparam int LINE_W = 128;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2,
    MEM_ERR   = 3'd7
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  // Types 3..7 fall through to read behaviour.
  function automatic logic is_store(input logic [2:0] t);
    return (t == MEM_WRITE) || (t == MEM_INIT);
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int p_num_lines = 16,
  parameter int p_idx_w     = $clog2(p_num_lines)
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [p_idx_w-1:0] i_widx,
  input  logic [LINE_W-1:0]  i_wdata,
  input  logic [p_idx_w-1:0] i_ridx,
  output logic [LINE_W-1:0]  o_rdata
);

  logic [LINE_W-1:0] r_mem [p_num_lines];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/line_mem_responder.sv
// Latency-configurable 128-bit line memory with val/rdy request/response.
// Define LINE_MEM_RESPONDER_OOB_CHECK_EN to reject addresses above the array.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int p_num_lines = 16,
  parameter int p_latency   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  input  logic [2:0]        memreq_type,
  input  logic [7:0]        memreq_opaque,
  input  logic [31:0]       memreq_addr,
  input  logic [LINE_W-1:0] memreq_data,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic [2:0]        memresp_type,
  output logic [7:0]        memresp_opaque,
  output logic [LINE_W-1:0] memresp_data
);

  localparam int IW = $clog2(p_num_lines);

  state_e            r_state;
  state_e            w_next;
  logic              r_alive;
  logic [3:0]        r_cnt;
  logic [2:0]        r_type;
  logic [7:0]        r_opq;
  logic [IW-1:0]     r_idx;
  logic [LINE_W-1:0] r_data;
  logic              r_oob;
  logic [LINE_W-1:0] r_resp_data;

  logic              w_xfer;
  logic              w_req_oob;
  logic              w_unused;
  logic              w_enter;
  logic              w_we;
  logic [2:0]        w_acc_type;
  logic [IW-1:0]     w_acc_idx;
  logic [LINE_W-1:0] w_acc_data;
  logic              w_acc_oob;
  logic [LINE_W-1:0] w_rd_data;

  assign memreq_rdy = r_alive && (r_state == S_IDLE);
  assign w_xfer     = memreq_val && memreq_rdy;

`ifdef LINE_MEM_RESPONDER_OOB_CHECK_EN
  assign w_req_oob = |memreq_addr[31:4+IW];
  assign w_unused  = ^memreq_addr[3:0];
`else
  assign w_req_oob = 1'b0;
  assign w_unused  = ^{memreq_addr[31:4+IW], memreq_addr[3:0]};
`endif

  // With zero latency the access happens on the transfer edge itself,
  // so the request fields are used before they are latched.
  always_comb begin
    w_acc_type = r_type;
    w_acc_idx  = r_idx;
    w_acc_data = r_data;
    w_acc_oob  = r_oob;
    if (r_state == S_IDLE) begin
      w_acc_type = memreq_type;
      w_acc_idx  = memreq_addr[4+IW-1:4];
      w_acc_data = memreq_data;
      w_acc_oob  = w_req_oob;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer)
          w_next = (p_latency == 0) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        if (memresp_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_we    = w_enter && is_store(w_acc_type) && !w_acc_oob;

  line_mem_array #(
    .p_num_lines (p_num_lines),
    .p_idx_w     (IW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_acc_idx),
    .i_wdata (w_acc_data),
    .i_ridx  (w_acc_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_alive     <= 1'b0;
      r_cnt       <= 4'd0;
      r_type      <= 3'd0;
      r_opq       <= 8'd0;
      r_idx       <= '0;
      r_data      <= '0;
      r_oob       <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
      if (w_xfer) begin
        r_cnt  <= 4'(p_latency);
        r_type <= memreq_type;
        r_opq  <= memreq_opaque;
        r_idx  <= memreq_addr[4+IW-1:4];
        r_data <= memreq_data;
        r_oob  <= w_req_oob;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        if (is_store(w_acc_type) || w_acc_oob)
          r_resp_data <= '0;
        else
          r_resp_data <= w_rd_data;
      end
    end
  end

  assign memresp_val    = (r_state == S_RESP);
  assign memresp_opaque = memresp_val ? r_opq : 8'd0;
  assign memresp_data   = memresp_val ? r_resp_data : '0;
  assign memresp_type   = !memresp_val ? 3'd0 :
                          r_oob ? 3'(MEM_ERR) : r_type;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder against a line-array model.
module tb_line_mem_responder;
  import line_mem_pkg::*;

  localparam int LAT = 2;
  localparam int NL  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         req_val, req_rdy, resp_val, resp_rdy;
  logic [2:0]   req_type, resp_type;
  logic [7:0]   req_opq, resp_opq;
  logic [31:0]  req_addr;
  logic [127:0] req_data, resp_data;

  logic         b_val, b_rdy, b_rval, b_rrdy;
  logic [2:0]   b_type, b_rtype;
  logic [7:0]   b_opq, b_ropq;
  logic [31:0]  b_addr;
  logic [127:0] b_data, b_rdata;

  line_mem_responder #(.p_num_lines(NL), .p_latency(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .memreq_val(req_val), .memreq_rdy(req_rdy),
    .memreq_type(req_type), .memreq_opaque(req_opq),
    .memreq_addr(req_addr), .memreq_data(req_data),
    .memresp_val(resp_val), .memresp_rdy(resp_rdy),
    .memresp_type(resp_type), .memresp_opaque(resp_opq),
    .memresp_data(resp_data)
  );

  line_mem_responder #(.p_num_lines(NL), .p_latency(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .memreq_val(b_val), .memreq_rdy(b_rdy),
    .memreq_type(b_type), .memreq_opaque(b_opq),
    .memreq_addr(b_addr), .memreq_data(b_data),
    .memresp_val(b_rval), .memresp_rdy(b_rrdy),
    .memresp_type(b_rtype), .memresp_opaque(b_ropq),
    .memresp_data(b_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] model [NL];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] t, input logic [31:0] a,
                        input logic [127:0] d, input logic [7:0] o,
                        input int stall);
    int n, w, idx;
    bit oob, st;
    logic [2:0] et;
    logic [127:0] ed;
    idx = int'(a[7:4]);
    st  = (t == 3'd1) || (t == 3'd2);
`ifdef LINE_MEM_RESPONDER_OOB_CHECK_EN
    oob = (a[31:8] != 24'd0);
`else
    oob = 1'b0;
`endif
    et = oob ? 3'd7 : t;
    ed = (oob || st) ? 128'd0 : model[idx];
    if (!oob && st) model[idx] = d;

    @(negedge clk);
    req_val = 1'b1; req_type = t; req_addr = a;
    req_data = d; req_opq = o;
    w = 0;
    while (!req_rdy && w < 50) begin
      @(negedge clk); w++;
    end
    check("req_accept", req_rdy, 1);
    n = cyc;
    @(negedge clk);
    req_val = 1'b0;
    req_type = 3'($urandom);
    req_data = {$urandom, $urandom, $urandom, $urandom};
    w = 0;
    while (!resp_val && w < 40) begin
      @(negedge clk); w++;
    end
    check("latency", 128'(cyc - n), 128'(1 + LAT));
    check("resp_type", resp_type, et);
    check("resp_opq", resp_opq, o);
    check("resp_data", resp_data, ed);
    check("rdy_in_resp", req_rdy, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_val", resp_val, 1);
      check("stall_type", resp_type, et);
      check("stall_opq", resp_opq, o);
      check("stall_data", resp_data, ed);
      check("stall_rdy", req_rdy, 0);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check("val_drop", resp_val, 0);
    check("data_zero", resp_data, 0);
    check("rdy_back", req_rdy, 1);
  endtask

  initial begin
    int seen, n;
    logic [31:0] a;
    req_val = 1'b1; req_type = 3'd1; req_addr = 32'h30;
    req_data = '1; req_opq = 8'hAA; resp_rdy = 1'b0;
    b_val = 1'b0; b_type = 3'd0; b_addr = 32'd0;
    b_data = '0; b_opq = 8'd0; b_rrdy = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_resp_val", resp_val, 0);
      check("rst_resp_type", resp_type, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_opq", resp_opq, 0);
    end
    req_val = 1'b0;
    reset = 1'b1;
    #1 check("rdy_at_release", req_rdy, 0);
    @(negedge clk);
    check("rdy_after_release", req_rdy, 1);
    check("no_resp_after_rst", resp_val, 0);

    // zero-latency instance: response next cycle, back-to-back at N+2
    b_val = 1'b1; b_type = 3'd1; b_addr = 32'h10;
    b_data = {4{$urandom}}; b_opq = 8'h11;
    check("l0_accept", b_rdy, 1);
    n = cyc;
    @(negedge clk);
    check("l0_resp_cyc", 128'(cyc - n), 1);
    check("l0_resp_val", b_rval, 1);
    check("l0_resp_type", b_rtype, 1);
    check("l0_resp_opq", b_ropq, 8'h11);
    check("l0_resp_data", b_rdata, 0);
    check("l0_rdy_busy", b_rdy, 0);
    b_opq = 8'h12;
    @(negedge clk);
    check("l0_val_gap", b_rval, 0);
    check("l0_accept2", b_rdy, 1);
    @(negedge clk);
    b_val = 1'b0;
    check("l0_resp2_val", b_rval, 1);
    check("l0_resp2_opq", b_ropq, 8'h12);
    @(negedge clk);
    check("l0_idle", b_rval, 0);

    for (int i = 0; i < NL; i++)
      do_req(3'd2, 32'(i) << 4, {$urandom, $urandom, $urandom, $urandom},
             8'(i), 0);

    do_req(3'd2, 32'h30,
           128'hDEADBEEF_00000001_00000002_00000003, 8'h05, 0);
    do_req(3'd0, 32'h30, '0, 8'h06, 0);
    do_req(3'd0, 32'h30, '0, 8'h07, 5);

    do_req(3'd1, 32'hF0, {4{$urandom}}, 8'h20, 0);
    do_req(3'd1, 32'h00, {4{$urandom}}, 8'h21, 0);
    do_req(3'd1, 32'h100, {4{$urandom}}, 8'h22, 1);
    do_req(3'd0, 32'h00, '0, 8'h23, 0);
    do_req(3'd0, 32'hF0, '0, 8'h24, 0);

    // reset while the request is still in ACCESS
    @(negedge clk);
    req_val = 1'b1; req_type = 3'd0; req_addr = 32'h20; req_opq = 8'h33;
    @(negedge clk);
    req_val = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rdy", req_rdy, 0);
    check("midrst_val", resp_val, 0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_val) seen = 1;
    end
    check("midrst_no_resp", 128'(seen), 0);
    do_req(3'd0, 32'h20, '0, 8'h34, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFF;
      do_req(3'($urandom_range(0, 7)), a,
             {$urandom, $urandom, $urandom, $urandom},
             8'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
